// File: rtl/flow_match_seq.sv
// Sequential flow-rule matcher: scans a DEPTH-entry {vld, key} table one entry per cycle
// through an external comparator and reports the lowest-index valid match.
module flow_match_seq #(
  parameter int KEY_W = 2,
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [KEY_W-1:0] wr_key,
  input  logic             wr_vld,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] cmp_a,
  output logic [KEY_W-1:0] cmp_b,
  input  logic             cmp_match,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_hit,
  output logic [IDX_W-1:0] res_idx,
  output logic [7:0]       hit_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [KEY_W-1:0] tbl_key [DEPTH];
  logic [DEPTH-1:0] tbl_vld;
  logic [IDX_W-1:0] idx;
  logic [KEY_W-1:0] key_q;
  logic             entry_hit;
  logic             last_entry;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // key_ready depends only on state, and res_* stay frozen until res_ready is seen.
  assign key_ready = (state == IDLE);
  assign res_valid = (state == DONE);
  assign dbg_state = state;

  assign cmp_a      = (state == SCAN) ? key_q : '0;
  assign cmp_b      = (state == SCAN) ? tbl_key[idx] : '0;
  assign entry_hit  = cmp_match & tbl_vld[idx];
  assign last_entry = (idx == IDX_W'(DEPTH - 1));

  // Key storage carries no reset; only the valid bits need clearing to empty the table.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      tbl_key[wr_idx] <= wr_key;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      key_q   <= '0;
      res_hit <= 1'b0;
      res_idx <= '0;
      hit_cnt <= 8'd0;
      tbl_vld <= '0;
    end else begin
      if (wr_en) begin
        tbl_vld[wr_idx] <= wr_vld;
      end
      case (state)
        IDLE: begin
          if (key_valid) begin
            key_q <= key_in;
            idx   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (entry_hit) begin
            res_hit <= 1'b1;
            res_idx <= idx;
            hit_cnt <= hit_cnt + 8'd1;
            state   <= DONE;
          end else if (last_entry) begin
            res_hit <= 1'b0;
            res_idx <= '0;
            state   <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (res_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flow_match_seq.sv
// Directed and randomised lookups against a reference rule table; results are
// predicted at key acceptance, queued, and checked when res_valid appears.
module tb_flow_match_seq;

  localparam int KEY_W = 2;
  localparam int DEPTH = 8;
  localparam int IDX_W = 3;
  localparam int W     = IDX_W + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [KEY_W-1:0] wr_key;
  logic             wr_vld;
  logic             key_valid;
  logic             key_ready;
  logic [KEY_W-1:0] key_in;
  logic [KEY_W-1:0] cmp_a;
  logic [KEY_W-1:0] cmp_b;
  logic             cmp_match;
  logic             res_valid;
  logic             res_ready;
  logic             res_hit;
  logic [IDX_W-1:0] res_idx;
  logic [7:0]       hit_cnt;
  logic [1:0]       dbg_state;

  flow_match_seq #(.KEY_W(KEY_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key), .wr_vld(wr_vld),
    .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_match(cmp_match),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_hit(res_hit), .res_idx(res_idx), .hit_cnt(hit_cnt),
    .dbg_state(dbg_state)
  );

  // Downstream equality comparator.
  assign cmp_match = (cmp_a == cmp_b);

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [W-1:0]     exp_q[$];
  logic [KEY_W-1:0] m_key [DEPTH];
  logic             m_vld [DEPTH];
  logic [7:0]       exp_hit_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] model_lookup(input logic [KEY_W-1:0] key);
    for (int i = 0; i < DEPTH; i++) begin
      if (m_vld[i] && m_key[i] == key) return {1'b1, IDX_W'(i)};
    end
    return '0;
  endfunction

  task automatic write_rule(input int i, input logic [KEY_W-1:0] key, input logic vld);
    wr_en  = 1'b1;
    wr_idx = IDX_W'(i);
    wr_key = key;
    wr_vld = vld;
    @(posedge clk); #1;
    wr_en    = 1'b0;
    m_key[i] = key;
    m_vld[i] = vld;
  endtask

  task automatic lookup(input logic [KEY_W-1:0] key, input int hold);
    logic [W-1:0] pred;
    logic [W-1:0] got;
    logic [W-1:0] popped;
    int guard;
    int lat;
    int exp_lat;
    pred  = model_lookup(key);
    guard = 0;
    while (!key_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("key_ready_wait", {31'd0, key_ready}, 32'd1);
    key_in    = key;
    key_valid = 1'b1;
    exp_q.push_back(pred);
    @(posedge clk); #1;
    key_valid = 1'b0;
    key_in    = '0;
    check("key_ready_busy", {31'd0, key_ready}, 32'd0);
    lat = 1;
    while (!res_valid && lat < 40) begin
      check("scan_cmp_a", {30'd0, cmp_a}, {30'd0, key});
      if (lat - 1 < DEPTH) check("scan_cmp_b", {30'd0, cmp_b}, {30'd0, m_key[lat-1]});
      @(posedge clk); #1;
      lat++;
    end
    check("res_valid", {31'd0, res_valid}, 32'd1);
    exp_lat = pred[IDX_W] ? int'(pred[IDX_W-1:0]) + 2 : DEPTH + 1;
    check("latency", lat, exp_lat);
    if (res_valid) begin
      got    = {res_hit, res_idx};
      popped = exp_q.pop_front();
      check("result", {28'd0, got}, {28'd0, popped});
      if (popped[IDX_W]) exp_hit_cnt = exp_hit_cnt + 8'd1;
      check("hit_cnt", {24'd0, hit_cnt}, {24'd0, exp_hit_cnt});
      check("done_cmp_zero", {28'd0, cmp_a, cmp_b}, 32'd0);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check("hold_valid", {31'd0, res_valid}, 32'd1);
        check("hold_result", {28'd0, res_hit, res_idx}, {28'd0, got});
        check("hold_key_ready", {31'd0, key_ready}, 32'd0);
      end
      // A key offered in the release cycle must not be taken.
      res_ready = 1'b1;
      key_valid = 1'b1;
      key_in    = key;
      @(posedge clk); #1;
      res_ready = 1'b0;
      key_valid = 1'b0;
      check("release_idle", {31'd0, key_ready}, 32'd1);
      check("release_valid", {31'd0, res_valid}, 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_key = '0; wr_vld = 1'b0;
    key_valid = 1'b0; key_in = '0; res_ready = 1'b0;
    exp_hit_cnt = 8'd0;
    for (int i = 0; i < DEPTH; i++) begin
      m_key[i] = '0;
      m_vld[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_key_ready", {31'd0, key_ready}, 32'd1);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_cmp", {28'd0, cmp_a, cmp_b}, 32'd0);
    check("rst_hit_cnt", {24'd0, hit_cnt}, 32'd0);
    check("rst_res", {28'd0, res_hit, res_idx}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < DEPTH; i++) write_rule(i, 2'b00, 1'b0);

    // Hit at entry 0.
    write_rule(0, 2'b01, 1'b1);
    lookup(2'b01, 0);

    // Lowest of two matching entries wins.
    write_rule(1, 2'b00, 1'b1);
    write_rule(2, 2'b10, 1'b1);
    write_rule(3, 2'b00, 1'b1);
    write_rule(4, 2'b00, 1'b1);
    write_rule(5, 2'b10, 1'b1);
    write_rule(6, 2'b00, 1'b1);
    write_rule(7, 2'b00, 1'b1);
    lookup(2'b10, 0);

    // Matching key in an invalid entry is a miss.
    write_rule(3, 2'b11, 1'b0);
    lookup(2'b11, 0);

    // Backpressure.
    lookup(2'b10, 5);

    for (int n = 0; n < 8; n++) begin
      write_rule($urandom_range(0, DEPTH - 1), KEY_W'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      lookup(KEY_W'($urandom_range(0, 3)), $urandom_range(0, 2));
    end

    // Reset mid-scan, with a concurrent write that must be dropped.
    for (int i = 0; i < DEPTH; i++) write_rule(i, 2'b00, 1'b1);
    write_rule(6, 2'b11, 1'b1);
    key_in = 2'b11;
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    wr_en = 1'b1; wr_idx = 3'd1; wr_key = 2'b11; wr_vld = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wr_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
    exp_hit_cnt = 8'd0;
    check("midrst_key_ready", {31'd0, key_ready}, 32'd1);
    check("midrst_res_valid", {31'd0, res_valid}, 32'd0);
    check("midrst_hit_cnt", {24'd0, hit_cnt}, 32'd0);
    check("midrst_cmp", {28'd0, cmp_a, cmp_b}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("midrst_no_result", {31'd0, res_valid}, 32'd0);
    end
    lookup(2'b11, 0);

    // hit_cnt wrap after 256 hits.
    write_rule(0, 2'b01, 1'b1);
    for (int n = 0; n < 256; n++) lookup(2'b01, 0);
    check("hit_cnt_wrap", {24'd0, hit_cnt}, 32'd0);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
